// File: rtl/demux8_pkg.sv
// Shared constants and state encoding for the 1:8 serial-to-parallel demultiplexer.
package demux8_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } demux_state_t;

endpackage

// File: rtl/demux1_8_dec.sv
// One-hot lane write-enable decoder: purely combinational, zero latency.
// When en_i is low, no lane is enabled, so it never stalls anything itself.
module demux1_8_dec
    import demux8_pkg::*;
(
    input  logic [SEL_W-1:0] sel_i,
    input  logic             en_i,
    output logic [LANES-1:0] we_o
);

    always_comb begin
        we_o = '0;
        if (en_i) begin
            we_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1_8_sipo.sv
// Collects 8 serial samples into lanes; out_valid rises one cycle after the 8th accept.
// While a word is held, din_ready stays low until out_ready is seen, giving 8 samples per 9 cycles.
module demux1_8_sipo
    import demux8_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic                   flush,
    output logic [LANES*WIDTH-1:0] y,
    output logic [SEL_W-1:0]       sel,
    output logic                   out_valid,
    input  logic                   out_ready
);

    demux_state_t           state_q;
    logic [SEL_W-1:0]       sel_q;
    logic                   out_valid_q;
    logic [LANES*WIDTH-1:0] lanes_q;
    logic [LANES*WIDTH-1:0] lanes_d;
    logic [LANES-1:0]       lane_we;
    logic                   accept;

    // din_ready is decoded from state alone so the source never sees a path from out_ready.
    assign din_ready = (state_q == FILL);
    assign accept    = din_valid && din_ready && !flush;

    demux1_8_dec u_dec (
        .sel_i (sel_q),
        .en_i  (accept),
        .we_o  (lane_we)
    );

    always_comb begin
        lanes_d = lanes_q;
        for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
                lanes_d[i*WIDTH +: WIDTH] = din;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    // Flush keeps lane contents; only the pointer and the pending word are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= FILL;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        sel_q <= sel_q + SEL_W'(1);
                        if (sel_q == SEL_W'(LANES - 1)) begin
                            state_q     <= FULL;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_q     <= FILL;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= FILL;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign y         = lanes_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;

endmodule
